// File: rtl/dphy_tx_burst_sched.sv
// D-PHY TX HS burst scheduler: round-robin link sharing between requesters,
// clock-lane handshake and data-lane LP-00 / HS-zero / payload / HS-trail sequencing.
module dphy_tx_burst_sched #(
  parameter int NUM_REQ     = 2,
  parameter int HS_PREP     = 4,
  parameter int HS_ZERO     = 10,
  parameter int HS_TRAIL    = 6,
  parameter int CLK_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hs_enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] eot,
  output logic [NUM_REQ-1:0] grant,
  output logic               burst_active,
  output logic               clk_hs_req,
  input  logic               clk_hs_active,
  output logic [2:0]         dl_mode,
  output logic               err_timeout,
  output logic               busy
);

  // state       | meaning
  // IDLE        | link in LP, waiting for an enabled request
  // CLK_WAIT    | clock lane asked for HS, waiting for ack (with timeout)
  // DL_PREP     | data lanes drive LP-00 for HS_PREP cycles
  // DL_ZERO     | data lanes drive HS-0 for HS_ZERO cycles
  // SEND        | owner drives payload until its eot
  // DL_TRAIL    | HS-trail for HS_TRAIL cycles, then chain or release
  // CLK_RELEASE | clock lane asked to leave HS, waiting for ack to drop

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(CLK_TIMEOUT) + 1;

  localparam logic [5:0]    PREP_LAST  = 6'(HS_PREP - 1);
  localparam logic [5:0]    ZERO_LAST  = 6'(HS_ZERO - 1);
  localparam logic [5:0]    TRAIL_LAST = 6'(HS_TRAIL - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(CLK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);

  localparam logic [2:0] DL_STOP  = 3'd0;
  localparam logic [2:0] DL_PREPM = 3'd1;
  localparam logic [2:0] DL_ZEROM = 3'd2;
  localparam logic [2:0] DL_DATA  = 3'd3;
  localparam logic [2:0] DL_TRAILM = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLK_WAIT,
    S_DL_PREP,
    S_DL_ZERO,
    S_SEND,
    S_DL_TRAIL,
    S_CLK_RELEASE
  } state_t;

  state_t         state, state_n;
  logic [IW-1:0]  owner, owner_n;
  logic [IW-1:0]  ptr, ptr_n;
  logic [5:0]     lane_cnt;
  logic [TW-1:0]  to_cnt;
  logic           err_n;

  logic [IW-1:0]  cand;
  logic [IW-1:0]  arb_idx;
  logic           arb_found;

  logic [NUM_REQ-1:0] grant_d;
  logic               burst_d;
  logic               hs_req_d;
  logic [2:0]         dl_mode_d;
  logic               busy_d;

  // Search starts at ptr, which already points one past the last owner.
  always_comb begin
    cand      = '0;
    arb_found = 1'b0;
    arb_idx   = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (hs_enable && arb_found) begin
          owner_n = arb_idx;
          state_n = S_CLK_WAIT;
        end
      end
      S_CLK_WAIT: begin
        if (clk_hs_active) begin
          state_n = S_DL_PREP;
        end else if (!hs_enable) begin
          state_n = S_CLK_RELEASE;
        end else if (to_cnt == TO_LAST) begin
          state_n = S_CLK_RELEASE;
          err_n   = 1'b1;
        end
      end
      S_DL_PREP: begin
        if (!hs_enable) begin
          state_n = S_CLK_RELEASE;
        end else if (lane_cnt == PREP_LAST) begin
          state_n = S_DL_ZERO;
        end
      end
      S_DL_ZERO: begin
        if (!hs_enable) begin
          state_n = S_CLK_RELEASE;
        end else if (lane_cnt == ZERO_LAST) begin
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (eot[owner]) begin
          state_n = S_DL_TRAIL;
          ptr_n   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        end
      end
      S_DL_TRAIL: begin
        if (lane_cnt == TRAIL_LAST) begin
          if (hs_enable && arb_found) begin
            owner_n = arb_idx;
            state_n = S_DL_PREP;
          end else begin
            state_n = S_CLK_RELEASE;
          end
        end
      end
      S_CLK_RELEASE: begin
        if (!clk_hs_active) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    grant_d   = '0;
    burst_d   = 1'b0;
    hs_req_d  = 1'b0;
    dl_mode_d = DL_STOP;
    busy_d    = (state_n != S_IDLE);
    case (state_n)
      S_CLK_WAIT: hs_req_d = 1'b1;
      S_DL_PREP: begin
        hs_req_d  = 1'b1;
        dl_mode_d = DL_PREPM;
        grant_d   = ONE << owner_n;
      end
      S_DL_ZERO: begin
        hs_req_d  = 1'b1;
        dl_mode_d = DL_ZEROM;
        grant_d   = ONE << owner_n;
      end
      S_SEND: begin
        hs_req_d  = 1'b1;
        dl_mode_d = DL_DATA;
        grant_d   = ONE << owner_n;
        burst_d   = 1'b1;
      end
      S_DL_TRAIL: begin
        hs_req_d  = 1'b1;
        dl_mode_d = DL_TRAILM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      owner        <= '0;
      ptr          <= '0;
      lane_cnt     <= '0;
      to_cnt       <= '0;
      grant        <= '0;
      burst_active <= 1'b0;
      clk_hs_req   <= 1'b0;
      dl_mode      <= DL_STOP;
      err_timeout  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      ptr          <= ptr_n;
      lane_cnt     <= (state_n != state) ? '0 : lane_cnt + 1'b1;
      if (state_n != state)
        to_cnt <= '0;
      else if (state == S_CLK_WAIT)
        to_cnt <= to_cnt + 1'b1;
      grant        <= grant_d;
      burst_active <= burst_d;
      clk_hs_req   <= hs_req_d;
      dl_mode      <= dl_mode_d;
      err_timeout  <= err_n;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_dphy_tx_burst_sched.sv
// Directed bench for dphy_tx_burst_sched with a 3-cycle clock-lane ack model
// and a requester model that raises eot on the data_len-th payload cycle.
module tb_dphy_tx_burst_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs_enable;
  logic [1:0] req;
  logic [1:0] eot;
  logic [1:0] grant;
  logic       burst_active;
  logic       clk_hs_req;
  logic       clk_hs_active;
  logic [2:0] dl_mode;
  logic       err_timeout;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int data_len = 8;
  int dcnt = 0;
  logic       ack_en = 1'b1;
  logic [2:0] sh = 3'b000;

  dphy_tx_burst_sched dut (
    .clk(clk), .rst(rst), .hs_enable(hs_enable), .req(req), .eot(eot),
    .grant(grant), .burst_active(burst_active), .clk_hs_req(clk_hs_req),
    .clk_hs_active(clk_hs_active), .dl_mode(dl_mode),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sh <= {sh[1:0], clk_hs_req & ack_en};
  assign clk_hs_active = sh[2];

  always @(negedge clk) begin
    if (burst_active === 1'b1) begin
      eot = (dcnt == data_len - 1) ? grant : 2'b00;
      dcnt++;
    end else begin
      eot = 2'b00;
      dcnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_len(input logic [2:0] m, output int n, output logic req_all);
    n = 0;
    req_all = 1'b1;
    while (dl_mode === m && n < 300) begin
      if (clk_hs_req !== 1'b1) req_all = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; hs_enable = 1'b0; req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({grant, burst_active, clk_hs_req, dl_mode, err_timeout, busy} !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", {grant, burst_active, clk_hs_req, dl_mode, err_timeout, busy});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_single;
    int n; logic ra;
    data_len = 8; hs_enable = 1'b1; req = 2'b01;
    @(negedge clk);
    total++;
    if (clk_hs_req !== 1'b1 || grant !== 2'b00) begin
      bad++; $display("FAIL t1_req_rise: clk_hs_req=%b grant=%b want 1/00", clk_hs_req, grant);
    end
    run_len(3'd0, n, ra);
    total++;
    if (n !== 4 || ra !== 1'b1) begin bad++; $display("FAIL t1_clk_wait: len=%0d req_all=%b want 4/1", n, ra); end
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL t1_grant_prep: got %b want 01", grant); end
    req = 2'b00;
    run_len(3'd1, n, ra);
    total++;
    if (n !== 4) begin bad++; $display("FAIL t1_prep_len: got %0d want 4", n); end
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL t1_grant_zero: got %b want 01", grant); end
    run_len(3'd2, n, ra);
    total++;
    if (n !== 10) begin bad++; $display("FAIL t1_zero_len: got %0d want 10", n); end
    total++;
    if (grant !== 2'b01 || burst_active !== 1'b1) begin
      bad++; $display("FAIL t1_data_start: grant=%b burst=%b want 01/1", grant, burst_active);
    end
    run_len(3'd3, n, ra);
    total++;
    if (n !== 8) begin bad++; $display("FAIL t1_data_len: got %0d want 8", n); end
    total++;
    if (grant !== 2'b00 || burst_active !== 1'b0 || clk_hs_req !== 1'b1) begin
      bad++; $display("FAIL t1_trail_start: grant=%b burst=%b hsreq=%b want 00/0/1", grant, burst_active, clk_hs_req);
    end
    run_len(3'd4, n, ra);
    total++;
    if (n !== 6) begin bad++; $display("FAIL t1_trail_len: got %0d want 6", n); end
    total++;
    if (clk_hs_req !== 1'b0 || dl_mode !== 3'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL t1_release: hsreq=%b mode=%0d busy=%b want 0/0/1", clk_hs_req, dl_mode, busy);
    end
    wait_idle(n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL t1_release_len: got %0d want 4", n); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_g [3];
    int np, nz, nd, nt, n; logic ra, req_all;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    do_reset;
    data_len = 4; hs_enable = 1'b1; req = 2'b11;
    @(negedge clk);
    run_len(3'd0, n, ra);
    req_all = 1'b1;
    for (int b = 0; b < 3; b++) begin
      total++;
      if (grant !== exp_g[b] || dl_mode !== 3'd1) begin
        bad++; $display("FAIL t2_grant_%0d: grant=%b mode=%0d want %b/1", b, grant, dl_mode, exp_g[b]);
      end
      run_len(3'd1, np, ra); req_all &= ra;
      run_len(3'd2, nz, ra); req_all &= ra;
      if (b == 2) req = 2'b00;
      run_len(3'd3, nd, ra); req_all &= ra;
      run_len(3'd4, nt, ra); req_all &= ra;
      total++;
      if (np !== 4 || nz !== 10 || nd !== 4 || nt !== 6) begin
        bad++; $display("FAIL t2_phases_%0d: prep=%0d zero=%0d data=%0d trail=%0d want 4/10/4/6", b, np, nz, nd, nt);
      end
    end
    total++;
    if (req_all !== 1'b1) begin bad++; $display("FAIL t2_hsreq_held: got %b want 1", req_all); end
    total++;
    if (clk_hs_req !== 1'b0 || dl_mode !== 3'd0) begin
      bad++; $display("FAIL t2_release: hsreq=%b mode=%0d want 0/0", clk_hs_req, dl_mode);
    end
    wait_idle(n);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL t2_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_timeout;
    int k, errs, n; logic gseen;
    ack_en = 1'b0; hs_enable = 1'b1; req = 2'b01;
    @(negedge clk);
    k = 0; gseen = 1'b0;
    while (err_timeout !== 1'b1 && k < 200) begin
      if (grant !== 2'b00) gseen = 1'b1;
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== 64) begin bad++; $display("FAIL t3_timeout_at: got %0d want 64", k); end
    total++;
    if (clk_hs_req !== 1'b0) begin bad++; $display("FAIL t3_hsreq_fall: got %b want 0", clk_hs_req); end
    req = 2'b00;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) errs++;
      if (grant !== 2'b00) gseen = 1'b1;
    end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL t3_single_pulse: extra pulses=%0d want 0", errs); end
    total++;
    if (busy !== 1'b0 || gseen !== 1'b0) begin
      bad++; $display("FAIL t3_idle_nogrant: busy=%b grant_seen=%b want 0/0", busy, gseen);
    end
    ack_en = 1'b1;
    wait_idle(n);
  endtask

  task automatic test_abort_zero;
    int n; logic ra;
    hs_enable = 1'b1; req = 2'b11;
    @(negedge clk);
    run_len(3'd0, n, ra);
    total++;
    if (grant !== 2'b10) begin bad++; $display("FAIL t4_first_grant: got %b want 10", grant); end
    run_len(3'd1, n, ra);
    for (int i = 0; i < 4; i++) @(negedge clk);
    total++;
    if (dl_mode !== 3'd2) begin bad++; $display("FAIL t4_in_zero: mode=%0d want 2", dl_mode); end
    hs_enable = 1'b0;
    @(negedge clk);
    total++;
    if (dl_mode !== 3'd0 || grant !== 2'b00 || clk_hs_req !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL t4_abort: mode=%0d grant=%b hsreq=%b busy=%b want 0/00/0/1", dl_mode, grant, clk_hs_req, busy);
    end
    wait_idle(n);
    hs_enable = 1'b1;
    @(negedge clk);
    run_len(3'd0, n, ra);
    total++;
    if (grant !== 2'b10) begin bad++; $display("FAIL t4_same_winner: got %b want 10", grant); end
    req = 2'b00; data_len = 4;
    run_len(3'd1, n, ra);
    run_len(3'd2, n, ra);
    run_len(3'd3, n, ra);
    run_len(3'd4, n, ra);
    wait_idle(n);
  endtask

  task automatic test_disable_in_send;
    int n; logic ra, stayed;
    hs_enable = 1'b1; req = 2'b01; data_len = 8;
    @(negedge clk);
    run_len(3'd0, n, ra);
    run_len(3'd1, n, ra);
    run_len(3'd2, n, ra);
    hs_enable = 1'b0;
    run_len(3'd3, n, ra);
    total++;
    if (n !== 8) begin bad++; $display("FAIL t5_data_len: got %0d want 8", n); end
    run_len(3'd4, n, ra);
    total++;
    if (n !== 6) begin bad++; $display("FAIL t5_trail_len: got %0d want 6", n); end
    total++;
    if (dl_mode !== 3'd0 || clk_hs_req !== 1'b0 || grant !== 2'b00) begin
      bad++; $display("FAIL t5_release: mode=%0d hsreq=%b grant=%b want 0/0/00", dl_mode, clk_hs_req, grant);
    end
    wait_idle(n);
    stayed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) stayed = 1'b0;
    end
    total++;
    if (stayed !== 1'b1) begin bad++; $display("FAIL t5_req_ignored: stayed_idle=%b want 1", stayed); end
    req = 2'b00;
  endtask

  task automatic test_reset_in_send;
    int n; logic ra;
    hs_enable = 1'b1; req = 2'b01; data_len = 50;
    @(negedge clk);
    run_len(3'd0, n, ra);
    req = 2'b00;
    run_len(3'd1, n, ra);
    run_len(3'd2, n, ra);
    @(negedge clk);
    total++;
    if (burst_active !== 1'b1) begin bad++; $display("FAIL t6_in_send: burst=%b want 1", burst_active); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({grant, burst_active, clk_hs_req, dl_mode, err_timeout, busy} !== 9'd0) begin
      bad++; $display("FAIL t6_async_reset: got %b want 0", {grant, burst_active, clk_hs_req, dl_mode, err_timeout, busy});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; data_len = 4;
    for (int i = 0; i < 5; i++) @(negedge clk);
    req = 2'b11;
    @(negedge clk);
    run_len(3'd0, n, ra);
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL t6_ptr_reset: got %b want 01", grant); end
    req = 2'b00;
    run_len(3'd1, n, ra);
    run_len(3'd2, n, ra);
    run_len(3'd3, n, ra);
    run_len(3'd4, n, ra);
    wait_idle(n);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL t6_final_idle: busy=%b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1; hs_enable = 1'b0; req = 2'b00; eot = 2'b00;
    test_reset;
    test_single;
    test_back_to_back;
    test_timeout;
    test_abort_zero;
    test_disable_in_send;
    test_reset_in_send;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
